// File: rtl/gpio_ctrl_pkg.sv
// Shared GPIO definitions: register word offsets and the window base,
// kept in one place so the address decoder and this block agree.
package gpio_ctrl_pkg;

    localparam int unsigned GPIO_BASE_WORD = 4096;

    localparam logic [1:0] GPIO_OUT_OFS  = 2'd0;
    localparam logic [1:0] GPIO_DIR_OFS  = 2'd1;
    localparam logic [1:0] GPIO_IN_OFS   = 2'd2;
    localparam logic [1:0] GPIO_EDGE_OFS = 2'd3;

endpackage

// File: rtl/gpio_ctrl_sync.sv
// Pin input synchroniser (s1, s2) plus a third stage for rising-edge detection.
module gpio_sync #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] s1_q, s2_q, s3_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign sync_o = s2_q;
    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO responder: OUT/DIR/IN/EDGE registers behind the data-bus decoder,
// with registered 1-cycle read return matching the data RAM.
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int GPIO_W    = 8,
    parameter int BASE_WORD = int'(GPIO_BASE_WORD)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_en_i,
    input  logic [AW-1:0]     rd_addr_i,
    input  logic              wr_en_i,
    input  logic [3:0]        wr_strb_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DW-1:0]     wr_data_i,
    output logic [DW-1:0]     rd_data_o,
    output logic              rd_valid_o,
    input  logic [GPIO_W-1:0] gpio_in_i,
    output logic [GPIO_W-1:0] gpio_out_o,
    output logic [GPIO_W-1:0] gpio_oe_o,
    output logic              irq_o
);

    localparam int WW = AW - 2;
    localparam logic [WW-1:0] BASE_V = WW'(BASE_WORD);

    logic [GPIO_W-1:0] out_q, out_d, dir_q, dir_d, edge_q, edge_d;
    logic [DW-1:0]     rd_data_q, rd_data_d, rd_mux;
    logic              rd_valid_q, irq_q;
    logic [GPIO_W-1:0] sync_in, rise, wmask, wdata, w1c;
    logic [WW-1:0]     rd_off, wr_off;
    logic              rd_in_win, wr_in_win;

    gpio_sync #(.W(GPIO_W)) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (gpio_in_i),
        .sync_o (sync_in),
        .rise_o (rise)
    );

    // Word offset within the window; anything past the 4 registers is a hole.
    assign rd_off    = rd_addr_i[AW-1:2] - BASE_V;
    assign wr_off    = wr_addr_i[AW-1:2] - BASE_V;
    assign rd_in_win = (rd_off[WW-1:2] == '0);
    assign wr_in_win = (wr_off[WW-1:2] == '0);

    for (genvar i = 0; i < GPIO_W; i++) begin : g_lane
        assign wmask[i] = wr_strb_i[i/8];
    end
    assign wdata = wr_data_i[GPIO_W-1:0];

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        w1c   = '0;
        if (wr_en_i && wr_in_win) begin
            case (wr_off[1:0])
                GPIO_OUT_OFS:  out_d = (out_q & ~wmask) | (wdata & wmask);
                GPIO_DIR_OFS:  dir_d = (dir_q & ~wmask) | (wdata & wmask);
                GPIO_EDGE_OFS: w1c   = wdata & wmask;
                default:       ;
            endcase
        end
        // A new edge in the same cycle as its clear wins.
        edge_d = (edge_q & ~w1c) | rise;

        rd_mux = '0;
        if (rd_in_win) begin
            case (rd_off[1:0])
                GPIO_OUT_OFS:  rd_mux[GPIO_W-1:0] = out_q;
                GPIO_DIR_OFS:  rd_mux[GPIO_W-1:0] = dir_q;
                GPIO_IN_OFS:   rd_mux[GPIO_W-1:0] = sync_in;
                GPIO_EDGE_OFS: rd_mux[GPIO_W-1:0] = edge_q;
                default:       ;
            endcase
        end
        rd_data_d = rd_en_i ? rd_mux : rd_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q      <= '0;
            dir_q      <= '0;
            edge_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            edge_q     <= edge_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_en_i;
            irq_q      <= |edge_q;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign gpio_out_o = out_q;
    assign gpio_oe_o  = dir_q;
    assign irq_o      = irq_q;

    logic unused_bits;
    assign unused_bits = ^{rd_addr_i[1:0], wr_addr_i[1:0], wr_data_i, wr_strb_i};

endmodule
